// File: rtl/loader_ctrl_wb.sv
// UART-triggered boot-loader reset controller with a Wishbone register block.
// Define LOADER_CKSUM_EN to add a modulo-256 checksum of the loaded image at register 4.
module loader_ctrl_wb #(
    parameter int unsigned SYS_CLK_FREQ     = 100000000,
    parameter int unsigned TIMEOUT_CYCLES   = 2 * SYS_CLK_FREQ,
    parameter int unsigned RST_PULSE_CYCLES = 4,
    parameter logic [7:0]  SYNC_CHAR        = 8'h2d,
    parameter logic [7:0]  FILLER_CHAR      = 8'h5f,
    parameter logic [7:0]  TRIGGER_CHAR     = 8'h70
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    input  logic        uart_rx_irq,
    input  logic [7:0]  uart_rx_byte,
    output logic        reset_o,
    output logic        led1,
    output logic        led2,
    output logic        led4
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SYNC       = 3'd1;
    localparam logic [2:0] S_PULSE_LD   = 3'd2;
    localparam logic [2:0] S_WAIT_FIRST = 3'd3;
    localparam logic [2:0] S_STREAM     = 3'd4;
    localparam logic [2:0] S_PULSE_FIN  = 3'd5;
    localparam logic [2:0] S_PULSE_SW   = 3'd6;

    localparam logic [31:0] PULSE_LAST = 32'(RST_PULSE_CYCLES - 1);
    localparam logic [31:0] TMO_INIT   = 32'(TIMEOUT_CYCLES);

    logic [2:0]  state;
    logic [1:0]  cause;
    logic [1:0]  cause_next;
    logic        en;
    logic [31:0] timeout;
    logic [31:0] tmo_eff;
    logic [31:0] bytes;
    logic [31:0] idle_cnt;
    logic [31:0] pulse_cnt;
    logic        ack_r;
    logic        req;
    logic        wr;
    logic        wr_lane0;
    logic        sw_req;
    logic        pulse_done;
    logic [2:0]  reg_sel;
    logic [31:0] rd_data;
`ifdef LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;
    assign wb_ack_o   = ack_r & wb_cyc_i;

    assign reg_sel    = wb_adr_i[4:2];
    assign req        = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr         = req & wb_we_i;
    assign wr_lane0   = wr & wb_sel_i[0];
    assign sw_req     = wr_lane0 && (reg_sel == 3'd1) && wb_dat_i[0];
    assign tmo_eff    = (timeout == '0) ? 32'd1 : timeout;
    assign pulse_done = (pulse_cnt == PULSE_LAST);

    assign led1 = (state == S_IDLE);
    assign led2 = (state == S_SYNC);
    assign led4 = (state == S_STREAM);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0: rd_data[1:0] = cause;
            3'd1: rd_data[1]   = en;
            3'd2: rd_data      = timeout;
            3'd3: rd_data      = bytes;
`ifdef LOADER_CKSUM_EN
            3'd4: rd_data[7:0] = cksum;
`endif
            default: rd_data = '0;
        endcase
    end

    // W1C is applied first so a same-cycle hardware set overrides it.
    always_comb begin
        cause_next = cause;
        if (wr_lane0 && (reg_sel == 3'd0))
            cause_next = cause & ~wb_dat_i[1:0];
        if ((state == S_SYNC) && en && uart_rx_irq && (uart_rx_byte == TRIGGER_CHAR))
            cause_next[0] = 1'b1;
        if ((state == S_PULSE_FIN) && pulse_done)
            cause_next[0] = 1'b0;
        if ((state == S_IDLE) && sw_req)
            cause_next[1] = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r    <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ack_r <= req;
            if (req)
                wb_dat_o <= rd_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            reset_o   <= 1'b1;
            cause     <= '0;
            en        <= 1'b1;
            timeout   <= TMO_INIT;
            bytes     <= '0;
            idle_cnt  <= '0;
            pulse_cnt <= '0;
`ifdef LOADER_CKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            cause <= cause_next;
            if (wr_lane0 && (reg_sel == 3'd1))
                en <= wb_dat_i[1];
            if (wr && (reg_sel == 3'd2)) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (wb_sel_i[i])
                        timeout[8*i +: 8] <= wb_dat_i[8*i +: 8];
            end

            case (state)
                S_IDLE: begin
                    if (sw_req) begin
                        state     <= S_PULSE_SW;
                        reset_o   <= 1'b0;
                        pulse_cnt <= '0;
                    end else if (uart_rx_irq && (uart_rx_byte == SYNC_CHAR) && en) begin
                        state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (uart_rx_irq) begin
                        if (uart_rx_byte == TRIGGER_CHAR) begin
                            state     <= S_PULSE_LD;
                            reset_o   <= 1'b0;
                            pulse_cnt <= '0;
                            bytes     <= '0;
`ifdef LOADER_CKSUM_EN
                            cksum     <= '0;
`endif
                        end else if (uart_rx_byte != FILLER_CHAR) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_PULSE_LD, S_PULSE_FIN, S_PULSE_SW: begin
                    if (pulse_done) begin
                        reset_o <= 1'b1;
                        state   <= (state == S_PULSE_LD) ? S_WAIT_FIRST : S_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 32'd1;
                    end
                end
                S_WAIT_FIRST: begin
                    if (uart_rx_irq) begin
                        state    <= S_STREAM;
                        bytes    <= 32'd1;
                        idle_cnt <= '0;
`ifdef LOADER_CKSUM_EN
                        cksum    <= cksum + uart_rx_byte;
`endif
                    end
                end
                S_STREAM: begin
                    if (uart_rx_irq) begin
                        if (bytes != '1)
                            bytes <= bytes + 32'd1;
                        idle_cnt <= '0;
`ifdef LOADER_CKSUM_EN
                        cksum    <= cksum + uart_rx_byte;
`endif
                    end else if (idle_cnt == tmo_eff) begin
                        state     <= S_PULSE_FIN;
                        reset_o   <= 1'b0;
                        pulse_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loader_ctrl_wb.sv
// Randomised scoreboard bench for loader_ctrl_wb: a timestamp-based reference model
// queues expected reads and reset pulses; negedge monitors pop and compare.
module tb_loader_ctrl_wb;

    localparam int N    = 4;
    localparam int TMO0 = 100;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, dat_w, dat_r;
    logic [3:0]  sel;
    logic        stall, ack, err;
    logic        irq;
    logic [7:0]  rxb;
    logic        core_rst_n, led1, led2, led4;

    always #5 clk = ~clk;

    loader_ctrl_wb #(
        .TIMEOUT_CYCLES  (TMO0),
        .RST_PULSE_CYCLES(N)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_w),
        .wb_sel_i    (sel),
        .wb_stall_o  (stall),
        .wb_ack_o    (ack),
        .wb_dat_o    (dat_r),
        .wb_err_o    (err),
        .uart_rx_irq (irq),
        .uart_rx_byte(rxb),
        .reset_o     (core_rst_n),
        .led1        (led1),
        .led2        (led2),
        .led4        (led4)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { bit rd; logic [31:0] data; logic [2:0] idx; } acc_t;
    typedef struct { int start; int width; } pulse_t;
    acc_t   rq[$];
    pulse_t pq[$];

    // Reference model: phases as flags, stream timeout from the last-byte timestamp.
    int              t = 0;
    bit              m_armed, m_pulse_on, m_waiting, m_streaming, m_ack;
    bit              m_en, m_cause_ld, m_cause_sw;
    int              m_pulse_end, m_pulse_kind, m_last_rx, m_sum;
    longint unsigned m_bytes;
    logic [31:0]     m_tmo;
    bit              mon_en = 1'b0;

    task automatic model_reset();
        m_armed = 0; m_pulse_on = 0; m_waiting = 0; m_streaming = 0; m_ack = 0;
        m_en = 1; m_cause_ld = 0; m_cause_sw = 0;
        m_bytes = 0; m_sum = 0; m_last_rx = 0; m_tmo = TMO0;
    endtask

    task automatic start_pulse(int kind);
        pulse_t p;
        m_pulse_on = 1; m_pulse_kind = kind; m_pulse_end = t + N;
        p.start = t; p.width = N;
        pq.push_back(p);
    endtask

    function automatic logic [31:0] model_read(logic [2:0] r);
        case (r)
            3'd0: return {30'd0, m_cause_sw, m_cause_ld};
            3'd1: return {30'd0, m_en, 1'b0};
            3'd2: return m_tmo;
            3'd3: return m_bytes[31:0];
`ifdef LOADER_CKSUM_EN
            3'd4: return 32'(m_sum);
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit          req, swrst, en_wr, new_en;
        logic [31:0] new_tmo;
        logic [2:0]  r;
        longint      tmo_eff;
        acc_t        a;
        t++;
        if (rst) begin
            if (m_pulse_on && pq.size() > 0)
                pq[pq.size()-1].width = t - pq[pq.size()-1].start;
            model_reset();
        end else begin
            req = cyc && stb && !m_ack;
            m_ack = req;
            swrst = 0; en_wr = 0; new_en = m_en; new_tmo = m_tmo;
            r = adr[4:2];
            if (req) begin
                a.rd = !we; a.data = model_read(r); a.idx = r;
                rq.push_back(a);
            end
            if (req && we) begin
                if (r == 3'd0 && sel[0]) begin
                    if (dat_w[0]) m_cause_ld = 0;
                    if (dat_w[1]) m_cause_sw = 0;
                end
                if (r == 3'd1 && sel[0]) begin
                    swrst = dat_w[0]; en_wr = 1; new_en = dat_w[1];
                end
                if (r == 3'd2)
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) new_tmo[8*b +: 8] = dat_w[8*b +: 8];
            end
            tmo_eff = (m_tmo == 0) ? 1 : longint'(m_tmo);
            if (m_pulse_on) begin
                if (t == m_pulse_end) begin
                    m_pulse_on = 0;
                    if (m_pulse_kind == 0) m_waiting = 1;
                    else if (m_pulse_kind == 1) m_cause_ld = 0;
                end
            end else if (m_armed) begin
                if (!m_en) m_armed = 0;
                else if (irq) begin
                    if (rxb == 8'h70) begin
                        m_armed = 0; start_pulse(0); m_cause_ld = 1; m_bytes = 0; m_sum = 0;
                    end else if (rxb != 8'h5f) m_armed = 0;
                end
            end else if (m_waiting) begin
                if (irq) begin
                    m_waiting = 0; m_streaming = 1; m_bytes = 1; m_last_rx = t;
                    m_sum = (m_sum + int'(rxb)) % 256;
                end
            end else if (m_streaming) begin
                if (irq) begin
                    if (m_bytes < 64'hFFFF_FFFF) m_bytes++;
                    m_last_rx = t;
                    m_sum = (m_sum + int'(rxb)) % 256;
                end else if (longint'(t - 1 - m_last_rx) == tmo_eff) begin
                    m_streaming = 0; start_pulse(1);
                end
            end else begin
                if (swrst) begin start_pulse(2); m_cause_sw = 1; end
                else if (irq && rxb == 8'h2d && m_en) m_armed = 1;
            end
            if (en_wr) m_en = new_en;
            m_tmo = new_tmo;
        end
    end

    // Monitor: acks and read data, reset pulses, state LEDs.
    bit prev_rst_o = 1'b1;
    int cur_start = 0;
    int cur_w = 0;
    always @(negedge clk) begin
        acc_t   a;
        pulse_t p;
        logic [4:0] exp_v;
        if (mon_en) begin
            if (ack || m_ack) begin
                checks++;
                if (ack !== m_ack) begin
                    failures++;
                    $display("FAIL wb_ack: got %b expected %b at edge %0d", ack, m_ack, t);
                end
                if (ack && rq.size() > 0) begin
                    a = rq.pop_front();
                    if (a.rd) begin
                        checks++;
                        if (dat_r !== a.data) begin
                            failures++;
                            $display("FAIL read reg%0d: got %h expected %h at edge %0d", a.idx, dat_r, a.data, t);
                        end
                    end
                end
            end
            if (!core_rst_n) begin
                if (prev_rst_o) begin cur_start = t; cur_w = 0; end
                cur_w++;
            end else if (!prev_rst_o) begin
                checks++;
                if (pq.size() == 0) begin
                    failures++;
                    $display("FAIL reset_pulse: got start %0d width %0d expected no pulse", cur_start, cur_w);
                end else begin
                    p = pq.pop_front();
                    if (p.start != cur_start || p.width != cur_w) begin
                        failures++;
                        $display("FAIL reset_pulse: got start %0d width %0d expected start %0d width %0d",
                                 cur_start, cur_w, p.start, p.width);
                    end
                end
            end
            prev_rst_o = core_rst_n;
            exp_v = {!(m_armed || m_pulse_on || m_waiting || m_streaming), m_armed, m_streaming, 2'b00};
            checks++;
            if ({led1, led2, led4, stall, err} !== exp_v) begin
                failures++;
                $display("FAIL leds: got %b expected %b at edge %0d", {led1, led2, led4, stall, err}, exp_v, t);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(logic [7:0] b);
        irq = 1'b1; rxb = b;
        tick(1);
        irq = 1'b0; rxb = 8'($urandom);
    endtask

    task automatic wb(bit w, logic [2:0] r, logic [31:0] d, logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = {27'($urandom), r, 2'($urandom)};
        dat_w = d; sel = s;
        tick(1);
        stb = 1'b0;
        tick(1);
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic rd(logic [2:0] r);
        wb(1'b0, r, $urandom, 4'hf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmo, nb;
        rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat_w = '0; sel = '0; irq = 0; rxb = '0;
        tick(3);
        mon_en = 1'b1;
        tick(1);
        rst = 0;
        tick(2);
        for (int r = 0; r < 8; r++) rd(3'(r));

        // Trigger with fillers, then a 10-byte stream spaced 20 cycles apart.
        send(8'h2d); tick(int'($urandom_range(0, 4)));
        send(8'h5f); tick(int'($urandom_range(0, 4)));
        send(8'h5f); tick(int'($urandom_range(0, 4)));
        send(8'h70);
        tick(N + 2); rd(0);
        for (int i = 0; i < 10; i++) begin send(8'($urandom)); tick(19); end
        tick(TMO0 + N + 10); rd(3); rd(0);

        send(8'h2d); tick(2); send(8'h41); tick(3); rd(0);

        // Byte lands exactly when the idle count reaches TIMEOUT.
        send(8'h2d); send(8'h70); tick(N + 1);
        send(8'($urandom)); tick(TMO0); send(8'($urandom));
        tick(TMO0 + N + 10); rd(3);

        // Software reset in IDLE, W1C, then ignored inside STREAM.
        wb(1, 3'd1, 32'h1, 4'h1); tick(N + 2); rd(0);
        wb(1, 3'd0, 32'h2, 4'h1); rd(0); rd(1);
        wb(1, 3'd1, 32'h2, 4'h1);
        send(8'h2d); send(8'h70); tick(N + 1);
        send(8'($urandom)); tick(5); wb(1, 3'd1, 32'h1, 4'h1); tick(5); send(8'($urandom));
        tick(TMO0 + N + 10); wb(1, 3'd1, 32'h2, 4'h1); rd(0);

        // W1C of CAUSE.LOADER on the same edge as the trigger: the set wins.
        send(8'h2d);
        irq = 1; rxb = 8'h70; cyc = 1; stb = 1; we = 1; adr = 32'h0; dat_w = 32'h3; sel = 4'h1;
        tick(1);
        irq = 0; stb = 0;
        tick(1);
        cyc = 0; we = 0;
        tick(N); rd(0); send(8'h11); tick(TMO0 + N + 10); rd(0);

        // EN gating: ignored sync while disabled, SYNC aborted when cleared.
        wb(1, 3'd1, 32'h0, 4'h1); send(8'h2d); tick(2);
        wb(1, 3'd1, 32'h2, 4'h1); send(8'h2d); tick(1);
        wb(1, 3'd1, 32'h0, 4'h1); tick(2); wb(1, 3'd1, 32'h2, 4'h1);

        wb(1, 3'd2, 32'h1234_5678, 4'b0101); rd(2);

        // Random sessions with random TIMEOUT (including 0) and a mid-stream rewrite.
        for (int s = 0; s < 4; s++) begin
            tmo = (s == 0) ? 0 : int'($urandom_range(1, 24));
            wb(1, 3'd2, 32'(tmo), 4'hf);
            repeat (3) begin send(8'($urandom)); tick(int'($urandom_range(0, 3))); end
            tick(2);
            send(8'h2d); send(8'h70); tick(N + 1);
            nb = int'($urandom_range(1, 12));
            for (int i = 0; i < nb; i++) begin
                send(8'($urandom));
                if (i == nb / 2 && s == 3) wb(1, 3'd2, 32'($urandom_range(2, 20)), 4'hf);
                tick(int'($urandom_range(0, tmo + 3)));
            end
            tick(40); rd(3); rd(4); rd(0);
        end

        // wb_rst_i in the second cycle of the loader pulse.
        send(8'h2d); send(8'h70); tick(1);
        rst = 1; tick(1); rst = 0;
        tick(2); rd(2); rd(0); rd(3);

        // Checksum of 0xFF + 0x02.
        send(8'h2d); send(8'h70); tick(N + 1);
        send(8'hff); tick(3); send(8'h02); tick(3); rd(4);
        tick(TMO0 + N + 10);

        tick(5);
        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL pulse_queue: got %0d outstanding expected 0", pq.size());
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL ack_queue: got %0d outstanding expected 0", rq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
